// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared types, arctangent table and gain constant for the CORDIC engine
package cordic_pkg;

    typedef enum logic {
        MODE_ROTATE = 1'b0,
        MODE_VECTOR = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        SCALE,
        DONE
    } state_e;

    // atan(2^-i) as a fraction of a full circle, scaled by 2^32
    localparam logic [31:0] ATAN32 [32] = '{
        32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
        32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
        32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
        32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D,
        32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518,
        32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051,
        32'h00000029, 32'h00000014, 32'h0000000A, 32'h00000005,
        32'h00000003, 32'h00000001, 32'h00000001, 32'h00000000
    };

    // 0.6072529350 scaled by 2^32
    localparam logic [31:0] K_INV32 = 32'h9B74EDA8;

    function automatic logic [31:0] atan_tbl(input int i, input int aw);
        logic [32:0] r;
        if (aw >= 32) return ATAN32[i[4:0]];
        r = {1'b0, ATAN32[i[4:0]]} + (33'd1 << (31 - aw));
        return 32'(r >> (32 - aw));
    endfunction

    function automatic logic [31:0] k_inv(input int kw);
        logic [32:0] r;
        if (kw >= 32) return K_INV32;
        r = {1'b0, K_INV32} + (33'd1 << (31 - kw));
        return 32'(r >> (32 - kw));
    endfunction

endpackage

// File: rtl/cordic_gain_scale.sv
// rtl/cordic_gain_scale.sv - multiply by inverse CORDIC gain, round half up, saturate to WIDTH
module cordic_gain_scale
    import cordic_pkg::*;
#(
    parameter int IW    = 18,
    parameter int WIDTH = 16,
    parameter int KW    = 16
) (
    input  logic signed [IW-1:0]    v,
    output logic signed [WIDTH-1:0] q
);

    localparam int PW = IW + KW + 1;
    localparam logic signed [KW:0]   K      = {1'b0, KW'(k_inv(KW))};
    localparam logic signed [PW-1:0] RND    = PW'(1) << (KW - 1);
    localparam logic signed [IW:0]   LIM_HI = (IW + 1)'((1 << (WIDTH - 1)) - 1);
    localparam logic signed [IW:0]   LIM_LO = ~LIM_HI;

    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] rnd;
    logic signed [IW:0]   shr;

    always_comb begin
        prod = PW'(v) * PW'(K);
        rnd  = prod + RND;
        shr  = rnd[PW-1:KW];
        if (shr > LIM_HI) begin
            q = WIDTH'(LIM_HI);
        end else if (shr < LIM_LO) begin
            q = WIDTH'(LIM_LO);
        end else begin
            q = WIDTH'(shr);
        end
    end

endmodule

// File: rtl/cordic_iter.sv
// rtl/cordic_iter.sv - iterative CORDIC, one micro-rotation per clock, rotate and vector modes
module cordic_iter
    import cordic_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int ANGLE_W = 16,
    parameter int ITERS   = 14,
    parameter int GUARD   = 2,
    parameter int KW      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_mode,
    input  logic signed [WIDTH-1:0]   in_x,
    input  logic signed [WIDTH-1:0]   in_y,
    input  logic [ANGLE_W-1:0]        in_angle,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [WIDTH-1:0]   out_x,
    output logic signed [WIDTH-1:0]   out_y,
    output logic [ANGLE_W-1:0]        out_z
);

    localparam int IW = WIDTH + GUARD;
    localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic [ANGLE_W-1:0] QUARTER = ANGLE_W'(1) << (ANGLE_W - 2);
    localparam logic [ANGLE_W-1:0] HALF    = ANGLE_W'(1) << (ANGLE_W - 1);
    localparam logic [CW-1:0]      LAST    = CW'(ITERS - 1);

    state_e                state, state_nxt;
    mode_e                 mode;
    logic [CW-1:0]         cnt;
    logic                  zero_flag;
    logic signed [IW-1:0]  x, y;
    logic [ANGLE_W-1:0]    z;
    logic signed [IW-1:0]  ext_x, ext_y, pre_x, pre_y;
    logic [ANGLE_W-1:0]    pre_z;
    logic signed [IW-1:0]  sx, sy, it_x, it_y;
    logic [ANGLE_W-1:0]    it_z;
    logic                  dir_pos;
    logic signed [WIDTH-1:0] sc_x, sc_y;
    logic [ANGLE_W-1:0]    atan_rom [2**CW];

    for (genvar g = 0; g < 2**CW; g++) begin : g_atan
        assign atan_rom[g] = (g < ITERS) ? ANGLE_W'(atan_tbl(g, ANGLE_W)) : '0;
    end

    // Fold the input into the right half-plane so the micro-rotations converge
    always_comb begin
        ext_x = IW'(in_x);
        ext_y = IW'(in_y);
        pre_x = ext_x;
        pre_y = ext_y;
        pre_z = in_angle;
        if (mode_e'(in_mode) == MODE_VECTOR) begin
            pre_z = '0;
            if (in_x[WIDTH-1]) begin
                pre_x = -ext_x;
                pre_y = -ext_y;
                pre_z = HALF;
            end
        end else begin
            case (in_angle[ANGLE_W-1 -: 2])
                2'b01: begin
                    pre_x = -ext_y;
                    pre_y = ext_x;
                    pre_z = in_angle - QUARTER;
                end
                2'b10: begin
                    pre_x = ext_y;
                    pre_y = -ext_x;
                    pre_z = in_angle + QUARTER;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        sx      = x >>> cnt;
        sy      = y >>> cnt;
        dir_pos = (mode == MODE_ROTATE) ? ~z[ANGLE_W-1] : y[IW-1];
        if (dir_pos) begin
            it_x = x - sy;
            it_y = y + sx;
            it_z = z - atan_rom[cnt];
        end else begin
            it_x = x + sy;
            it_y = y - sx;
            it_z = z + atan_rom[cnt];
        end
    end

    cordic_gain_scale #(.IW(IW), .WIDTH(WIDTH), .KW(KW)) u_gain_x (.v(x), .q(sc_x));
    cordic_gain_scale #(.IW(IW), .WIDTH(WIDTH), .KW(KW)) u_gain_y (.v(y), .q(sc_y));

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = ITER;
            end
            ITER:  if (cnt == LAST) state_nxt = SCALE;
            SCALE: state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mode      <= MODE_ROTATE;
            cnt       <= '0;
            zero_flag <= 1'b0;
            x         <= '0;
            y         <= '0;
            z         <= '0;
            out_x     <= '0;
            out_y     <= '0;
            out_z     <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (in_valid) begin
                    mode      <= mode_e'(in_mode);
                    cnt       <= '0;
                    zero_flag <= in_mode && (in_x == '0) && (in_y == '0);
                    x         <= pre_x;
                    y         <= pre_y;
                    z         <= pre_z;
                end
                ITER: begin
                    x   <= it_x;
                    y   <= it_y;
                    z   <= it_z;
                    cnt <= cnt + CW'(1);
                end
                SCALE: begin
                    out_x <= zero_flag ? '0 : sc_x;
                    out_y <= zero_flag ? '0 : sc_y;
                    out_z <= zero_flag ? '0 : z;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_iter.sv
// tb/tb_cordic_iter.sv - directed self-checking bench for cordic_iter
module tb_cordic_iter;

    localparam int WIDTH   = 16;
    localparam int ANGLE_W = 16;
    localparam int ITERS   = 14;
    localparam int TOL     = 4;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     in_valid;
    logic                     in_ready;
    logic                     in_mode;
    logic signed [WIDTH-1:0]  in_x;
    logic signed [WIDTH-1:0]  in_y;
    logic [ANGLE_W-1:0]       in_angle;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [WIDTH-1:0]  out_x;
    logic signed [WIDTH-1:0]  out_y;
    logic [ANGLE_W-1:0]       out_z;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cordic_iter #(
        .WIDTH(WIDTH), .ANGLE_W(ANGLE_W), .ITERS(ITERS), .GUARD(2), .KW(16)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_x(in_x), .in_y(in_y), .in_angle(in_angle),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_z(out_z)
    );

    task automatic check_eq(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_tol(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        logic signed [31:0] d;
        logic ok;
        d  = obs - exp;
        ok = (d <= TOL) && (d >= -TOL);
        checks++;
        assert (ok === 1'b1) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d +/-%0d", tag, obs, exp, TOL);
        end
    endtask

    task automatic check_ang(input string tag, input logic [ANGLE_W-1:0] obs, input logic [ANGLE_W-1:0] exp);
        logic signed [ANGLE_W-1:0] d;
        logic ok;
        d  = obs - exp;
        ok = (d <= TOL) && (d >= -TOL);
        checks++;
        assert (ok === 1'b1) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d +/-%0d", tag, obs, exp, TOL);
        end
    endtask

    task automatic run_job(input logic m, input int x, input int y, input int a, output int lat);
        @(negedge clk);
        in_mode  = m;
        in_x     = WIDTH'(x);
        in_y     = WIDTH'(y);
        in_angle = ANGLE_W'(a);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        logic stable;
        logic signed [WIDTH-1:0] hold_x, hold_y;
        logic [ANGLE_W-1:0] hold_z;

        rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; out_ready = 1'b0;
        in_x = '0; in_y = '0; in_angle = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_x", out_x, 0);
        check_eq("rst_out_y", out_y, 0);
        check_eq("rst_out_z", out_z, 0);
        @(negedge clk);
        rst = 1'b0;

        // ROTATE 30 degrees
        run_job(1'b0, 16384, 0, 5461, lat);
        check_eq("rot30_latency", lat, ITERS + 1);
        check_tol("rot30_x", out_x, 14189);
        check_tol("rot30_y", out_y, 8192);
        check_ang("rot30_z", out_z, 0);
        check_eq("done_in_ready", in_ready, 0);
        release_out();
        check_eq("release_out_valid", out_valid, 0);
        check_eq("release_in_ready", in_ready, 1);

        // ROTATE 150 degrees, second-quadrant pre-rotation
        run_job(1'b0, 16384, 0, 27307, lat);
        check_tol("rot150_x", out_x, -14189);
        check_tol("rot150_y", out_y, 8192);
        release_out();

        // VECTOR magnitude/angle of (0.75, 1.0)
        run_job(1'b1, 12288, 16384, 0, lat);
        check_tol("vec_mag", out_x, 20480);
        check_ang("vec_ang", out_z, 9672);
        release_out();

        // VECTOR of negative x, half-circle pre-rotation
        run_job(1'b1, -16384, 0, 0, lat);
        check_tol("vecneg_mag", out_x, 16384);
        check_ang("vecneg_ang", out_z, 16'h8000);
        release_out();

        // VECTOR of the origin forces zero outputs at full latency
        run_job(1'b1, 0, 0, 0, lat);
        check_eq("vec0_latency", lat, ITERS + 1);
        check_eq("vec0_x", out_x, 0);
        check_eq("vec0_y", out_y, 0);
        check_eq("vec0_z", out_z, 0);
        release_out();

        // VECTOR of (max, max): magnitude saturates
        run_job(1'b1, 32767, 32767, 0, lat);
        check_eq("vecsat_mag", out_x, 32767);
        check_ang("vecsat_ang", out_z, 8192);

        // Backpressure with a competing request
        hold_x = out_x; hold_y = out_y; hold_z = out_z;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_mode = 1'b0; in_x = 16'sd1000; in_y = 16'sd0; in_angle = 16'd0; in_valid = 1'b1;
            if (out_x !== hold_x || out_y !== hold_y || out_z !== hold_z ||
                out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
        end
        check_eq("backpressure_stable", stable, 1);
        in_valid = 1'b0;
        release_out();

        run_job(1'b0, 16384, 0, 5461, lat);
        check_eq("after_bp_latency", lat, ITERS + 1);
        check_tol("after_bp_x", out_x, 14189);
        check_tol("after_bp_y", out_y, 8192);
        release_out();

        // Reset during iteration 5 aborts the job
        @(negedge clk);
        in_mode = 1'b0; in_x = 16'sd16384; in_y = 16'sd0; in_angle = 16'd5461; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("abort_in_ready", in_ready, 1);
        check_eq("abort_out_valid", out_valid, 0);
        check_eq("abort_out_x", out_x, 0);
        check_eq("abort_out_y", out_y, 0);
        check_eq("abort_out_z", out_z, 0);

        run_job(1'b0, 16384, 0, 5461, lat);
        check_eq("post_rst_latency", lat, ITERS + 1);
        check_tol("post_rst_x", out_x, 14189);
        check_tol("post_rst_y", out_y, 8192);
        check_ang("post_rst_z", out_z, 0);
        release_out();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
